imm_extend_stage: RTL and testbench
===================================

Name: imm_extend_stage

Overview:
Parametrised successor to the decode-stage immediate extender.
- Takes the full 32-bit instruction word, not a pre-sliced field.
- Supports XLEN 32 or 64 and adds a CSR zero-extended immediate (Z-type).
- Registers the result in a 2-entry skid buffer with valid/ready handshakes, so decode can stall or flush without losing an extended immediate.
- Sits between the instruction-fetch/decode register and the ID/EX pipeline register.

Parameters:
XLEN, 32, output immediate width; legal values 32 or 64.
TAG_W, 32, width of the sideband tag (PC or instruction ID) carried alongside each entry.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  synchronous active-low reset.
flush  input  1  synchronous pipeline flush; discards all buffered entries.
in_valid  input  1  producer presents an instruction.
in_ready  output  1  stage can accept an entry this cycle.
in_instr  input  32  raw instruction word.
in_immsrc  input  3  immediate format select.
in_tag  input  TAG_W  sideband tag.
out_valid  output  1  head entry valid.
out_ready  input  1  consumer accepts the head entry.
out_immext  output  XLEN  extended immediate of the head entry.
out_tag  output  TAG_W  tag of the head entry.
out_illegal  output  1  head entry had an unsupported immsrc.

Behaviour:
- Decode (combinational, computed on the input side before storage). "sx" means replicate instr[31] up to XLEN.
  - 000 I: sx(instr[31:20]).
  - 001 S: sx({instr[31:25], instr[11:7]}).
  - 010 B: sx({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - 011 J: sx({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - 100 U: sx({instr[31:12], 12'b0}); at XLEN=64, bits 63:32 copy instr[31].
  - 101 Z: zero-extend instr[19:15].
  - 110/111: immext=0, illegal=1. Illegal is 0 for every other code.
- Storage: 2-entry FIFO of {immext, tag, illegal}, with head/tail pointers and a 2-bit count.
  - States: EMPTY (count=0), ONE (count=1), FULL (count=2).
- Handshakes:
  - in_ready = (count != 2). It depends only on state, with no combinational path from out_ready.
  - Push = in_valid & in_ready. Pop = out_valid & out_ready.
  - in_valid may be raised without waiting for in_ready. Producer holds inputs stable until accepted.
- Transitions:
  - EMPTY --push--> ONE.
  - ONE --push & !pop--> FULL.
  - ONE --pop & !push--> EMPTY.
  - ONE --push & pop--> ONE, with the new entry becoming the head next cycle.
  - FULL --pop--> ONE. No push is possible in FULL.
- Latency: 1 cycle from accepted input to out_valid; throughput 1 per cycle while out_ready=1.
- Ordering: strict FIFO. Pointers wrap modulo 2.
- out_valid = (count != 0). When out_valid=0, out_immext, out_tag and out_illegal are driven to 0.
- Flush: next cycle count=0 and pointers=0. Flush overrides a push or pop in the same cycle; an input presented with flush is dropped. in_ready stays as computed from current state.
- Reset (rst_n=0 at a clock edge): count=0, pointers=0, storage cleared. Post-reset outputs: out_valid=0, in_ready=1, out_immext=0, out_tag=0, out_illegal=0.
- Reset asserted mid-transfer drops all entries; reset has priority over flush.

Optional Feature:
IMM_EXTEND_BYPASS_EN.
- Defined: when count=0, in_valid=1, out_ready=1 and flush=0, the decoded input drives out_* combinationally with out_valid=1 and is not stored (0-cycle latency). When count=0, in_valid=1 and out_ready=0, the entry is stored normally.
- Undefined: no combinational in-to-out path; minimum latency 1 cycle.

Decomposition:
- Package imm_extend_pkg holds:
  - immsrc_e enum (IMM_I, IMM_S, IMM_B, IMM_J, IMM_U, IMM_Z).
  - entry struct {immext, tag, illegal}, parametrised via localparams.
  - Function imm_decode(instr, immsrc) returning the entry fields.
- One sub-module: imm_decode_xlen (pure combinational decoder, XLEN parameter). The top module holds the FIFO and control.

Test Plan:
- I-type, XLEN=32: instr 0xFFF00093, immsrc 000, out_ready=1 → next cycle out_valid=1, out_immext 0xFFFFFFFF, out_illegal 0. Repeat at XLEN=64 → 0xFFFFFFFFFFFFFFFF.
- Mixed formats back-to-back, out_ready=1:
  - 0x0020A423/001 → 0x00000008.
  - 0xFE000EE3/010 → 0xFFFFFFFC.
  - 0x123452B7/100 → 0x12345000.
  - 0x000FD073/101 → 0x0000001F.
  - One result per cycle, in order.
- Backpressure: out_ready=0, push tags 1,2 → in_ready=0 after second push, third input held. Raise out_ready → tags 1,2,3 emerge in order with nothing lost.
- Simultaneous push+pop in ONE over 10 cycles → count stays 1, each tag emerges exactly 1 cycle after acceptance.
- Illegal and flush:
  - immsrc 111 → out_immext 0, out_illegal 1.
  - Fill to FULL, assert flush together with in_valid → next cycle out_valid=0, in_ready=1, flushed input never emerges.
- Reset: drive rst_n=0 while FULL → next cycle all outputs 0, in_ready=1. With IMM_EXTEND_BYPASS_EN, EMPTY + in_valid + out_ready → out_valid same cycle.

Source files
------------

// File: rtl/imm_extend_pkg.sv
// rtl/imm_extend_pkg.sv - immediate format codes, occupancy states, entry struct and decode function
package imm_extend_pkg;

  localparam int IMM_XLEN_MAX  = 64;
  localparam int IMM_TAG_W_MAX = 64;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100,
    IMM_Z = 3'b101
  } immsrc_e;

  typedef enum logic [1:0] {
    CNT_EMPTY = 2'd0,
    CNT_ONE   = 2'd1,
    CNT_FULL  = 2'd2
  } count_e;

  typedef struct packed {
    logic [IMM_XLEN_MAX-1:0]  immext;
    logic [IMM_TAG_W_MAX-1:0] tag;
    logic                     illegal;
  } entry_t;

  // Decodes at the widest XLEN; narrower builds keep the low bits, which is exact
  // because every signed format replicates instr[31] all the way up.
  function automatic entry_t imm_decode(input logic [31:0] instr, input logic [2:0] immsrc);
    entry_t e;
    logic   s;
    e = '0;
    s = instr[31];
    case (immsrc_e'(immsrc))
      IMM_I:   e.immext = {{52{s}}, instr[31:20]};
      IMM_S:   e.immext = {{52{s}}, instr[31:25], instr[11:7]};
      IMM_B:   e.immext = {{51{s}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J:   e.immext = {{43{s}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_U:   e.immext = {{32{s}}, instr[31:12], 12'b0};
      IMM_Z:   e.immext = {59'b0, instr[19:15]};
      default: e.illegal = 1'b1;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/imm_decode_xlen.sv
// rtl/imm_decode_xlen.sv - combinational immediate decoder sized to XLEN
module imm_decode_xlen
  import imm_extend_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic [2:0]      immsrc,
  output logic [XLEN-1:0] immext,
  output logic            illegal
);

  entry_t dec;
  logic   unused_dec_bits;

  assign dec             = imm_decode(instr, immsrc);
  assign immext          = dec.immext[XLEN-1:0];
  assign illegal         = dec.illegal;
  assign unused_dec_bits = ^{dec.immext, dec.tag};

endmodule

// File: rtl/imm_extend_stage.sv
// rtl/imm_extend_stage.sv - 2-entry skid-buffered immediate extender; IMM_EXTEND_BYPASS_EN adds a 0-cycle bypass
module imm_extend_stage
  import imm_extend_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_immsrc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_immext,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  count_e            count_q, count_d;
  logic              head_q, tail_q;
  logic [XLEN-1:0]   mem_imm [2];
  logic [TAG_W-1:0]  mem_tag [2];
  logic              mem_ill [2];

  logic [XLEN-1:0]   dec_immext;
  logic              dec_illegal;
  logic              bypass, push, pop;

  imm_decode_xlen #(.XLEN(XLEN)) u_decode (
    .instr   (in_instr),
    .immsrc  (in_immsrc),
    .immext  (dec_immext),
    .illegal (dec_illegal)
  );

  assign in_ready = (count_q != CNT_FULL);

`ifdef IMM_EXTEND_BYPASS_EN
  assign bypass = (count_q == CNT_EMPTY) & in_valid & out_ready & ~flush;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed entry is consumed directly, so it never occupies storage.
  assign push = in_valid & in_ready & ~bypass;
  assign pop  = (count_q != CNT_EMPTY) & out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= CNT_EMPTY;
    end else if (flush) begin
      count_q <= CNT_EMPTY;
    end else begin
      count_q <= count_d;
    end
  end

  always_comb begin
    count_d = count_q;
    unique case (count_q)
      CNT_EMPTY: if (push) count_d = CNT_ONE;
      CNT_ONE: begin
        if (push && !pop)      count_d = CNT_FULL;
        else if (pop && !push) count_d = CNT_EMPTY;
      end
      CNT_FULL:  if (pop) count_d = CNT_ONE;
      default:   count_d = CNT_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q <= 1'b0;
      tail_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        mem_imm[i] <= '0;
        mem_tag[i] <= '0;
        mem_ill[i] <= 1'b0;
      end
    end else if (flush) begin
      head_q <= 1'b0;
      tail_q <= 1'b0;
    end else begin
      if (push) begin
        mem_imm[tail_q] <= dec_immext;
        mem_tag[tail_q] <= in_tag;
        mem_ill[tail_q] <= dec_illegal;
        tail_q          <= ~tail_q;
      end
      if (pop) begin
        head_q <= ~head_q;
      end
    end
  end

  always_comb begin
    out_valid   = 1'b0;
    out_immext  = '0;
    out_tag     = '0;
    out_illegal = 1'b0;
    if (count_q != CNT_EMPTY) begin
      out_valid   = 1'b1;
      out_immext  = mem_imm[head_q];
      out_tag     = mem_tag[head_q];
      out_illegal = mem_ill[head_q];
    end else if (bypass) begin
      out_valid   = 1'b1;
      out_immext  = dec_immext;
      out_tag     = in_tag;
      out_illegal = dec_illegal;
    end
  end

endmodule

// File: tb/tb_imm_extend_stage.sv
// tb/tb_imm_extend_stage.sv - scoreboard bench driving XLEN=32 and XLEN=64 instances in lockstep
module tb_imm_extend_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_tag;
  logic [2:0]  in_immsrc;

  logic        in_ready, out_valid, out_illegal;
  logic [31:0] out_immext, out_tag;
  logic        in_ready64, out_valid64, out_illegal64;
  logic [63:0] out_immext64;
  logic [31:0] out_tag64;

  typedef struct {
    logic [63:0] imm;
    logic [31:0] tag;
    logic        ill;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   mon_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  imm_extend_stage #(.XLEN(32), .TAG_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_immsrc(in_immsrc), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_immext(out_immext),
    .out_tag(out_tag), .out_illegal(out_illegal)
  );

  imm_extend_stage #(.XLEN(64), .TAG_W(32)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr),
    .in_immsrc(in_immsrc), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready), .out_immext(out_immext64),
    .out_tag(out_tag64), .out_illegal(out_illegal64)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Holds the input until accepted; the expected result is queued only when keep=1.
  task automatic send(input logic [31:0] instr, input logic [2:0] src, input logic [31:0] tag,
                      input logic [63:0] imm, input logic ill, input bit lat, input bit keep);
    in_valid  = 1'b1;
    in_instr  = instr;
    in_immsrc = src;
    in_tag    = tag;
    for (int i = 0; ; i++) begin
      @(negedge clk);
      if (in_ready) break;
      if (i >= 50) begin
        checks++;
        errors++;
        $display("FAIL send_timeout tag=%h in_ready=%b required=1", tag, in_ready);
        in_valid = 1'b0;
        return;
      end
    end
    if (keep) exp_q.push_back('{imm, tag, ill, cyc, lat});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (out_valid) begin
        check("valid64", {63'b0, out_valid64}, 64'd1);
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out actual_tag=%h required=none", out_tag);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("immext32", {32'b0, out_immext}, {32'b0, e.imm[31:0]});
            check("immext64", out_immext64, e.imm);
            check("tag", {32'b0, out_tag}, {32'b0, e.tag});
            check("illegal", {63'b0, out_illegal}, {63'b0, e.ill});
            if (e.lat) check("latency", 64'(cyc - e.acc), 64'd1);
          end
        end
      end else begin
        check("idle_zero", {out_immext, out_tag, 31'b0, out_illegal}, 64'd0);
        check("idle_zero64", out_immext64 | {32'b0, out_tag64} | {63'b0, out_illegal64}, 64'd0);
      end
    end
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_immsrc = '0; in_tag = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("rst_in_ready", {63'b0, in_ready}, 64'd1);
    check("rst_outputs", {out_immext, out_tag} | {63'b0, out_illegal}, 64'd0);
    check("rst_outputs64", out_immext64, 64'd0);
    @(posedge clk); #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // single I-type, then mixed formats back-to-back
    send(32'hFFF00093, 3'b000, 32'h10, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b1);
    repeat (2) @(posedge clk); #1;
    send(32'h0020A423, 3'b001, 32'h11, 64'h0000_0000_0000_0008, 1'b0, 1'b1, 1'b1);
    send(32'hFE000EE3, 3'b010, 32'h12, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b1, 1'b1);
    send(32'h123452B7, 3'b100, 32'h13, 64'h0000_0000_1234_5000, 1'b0, 1'b1, 1'b1);
    send(32'h000FD073, 3'b101, 32'h14, 64'h0000_0000_0000_001F, 1'b0, 1'b1, 1'b1);
    send(32'h008000EF, 3'b011, 32'h15, 64'h0000_0000_0000_0008, 1'b0, 1'b1, 1'b1);
    send(32'hFFDFF0EF, 3'b011, 32'h16, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b1, 1'b1);
    send(32'hFFFFF0B7, 3'b100, 32'h17, 64'hFFFF_FFFF_FFFF_F000, 1'b0, 1'b1, 1'b1);
    send(32'h12345678, 3'b111, 32'h18, 64'h0, 1'b1, 1'b1, 1'b1);
    send(32'hFFFFFFFF, 3'b110, 32'h19, 64'h0, 1'b1, 1'b1, 1'b1);
    repeat (2) @(posedge clk); #1;

    // backpressure: two entries fill the buffer, the third waits
    out_ready = 1'b0;
    send(32'h00100093, 3'b000, 32'h1, 64'h1, 1'b0, 1'b0, 1'b1);
    send(32'h00200093, 3'b000, 32'h2, 64'h2, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("full_in_ready", {63'b0, in_ready}, 64'd0);
    fork
      send(32'h00300093, 3'b000, 32'h3, 64'h3, 1'b0, 1'b0, 1'b1);
      begin
        repeat (3) @(negedge clk);
        check("held_in_ready", {63'b0, in_ready}, 64'd0);
        check("held_head_tag", {32'b0, out_tag}, 64'h1);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk); #1;

    // sustained push+pop while holding one entry
    for (int i = 0; i < 10; i++)
      send(32'h00000093 | (32'(i) << 20), 3'b000, 32'h40 + 32'(i), 64'(i), 1'b0, 1'b1, 1'b1);
    repeat (3) @(posedge clk); #1;

    // flush while FULL with an input presented
    out_ready = 1'b0;
    send(32'h00700093, 3'b000, 32'h21, 64'h7, 1'b0, 1'b0, 1'b0);
    send(32'h00800093, 3'b000, 32'h22, 64'h8, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1; in_instr = 32'h00900093; in_immsrc = 3'b000; in_tag = 32'h23; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_full_valid", {63'b0, out_valid}, 64'd0);
    check("flush_full_ready", {63'b0, in_ready}, 64'd1);

    // flush in ONE overrides an otherwise-accepted push
    @(posedge clk); #1;
    send(32'h00A00093, 3'b000, 32'h24, 64'hA, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1; in_instr = 32'h00B00093; in_tag = 32'h25; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_one_valid", {63'b0, out_valid}, 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (4) @(posedge clk); #1;

    // reset while FULL
    out_ready = 1'b0;
    send(32'h00C00093, 3'b000, 32'h31, 64'hC, 1'b0, 1'b0, 1'b0);
    send(32'h00D00093, 3'b000, 32'h32, 64'hD, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check("pre_rst_valid", {63'b0, out_valid}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    check("rst_full_valid", {63'b0, out_valid}, 64'd0);
    check("rst_full_ready", {63'b0, in_ready}, 64'd1);
    check("rst_full_outputs", {out_immext, out_tag} | {63'b0, out_illegal}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(32'h00500093, 3'b000, 32'h99, 64'h5, 1'b0, 1'b1, 1'b1);
    repeat (3) @(posedge clk); #1;

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
